// File: rtl/poly_mult_result_collector_if.sv
// ---------------------------------------------------------------------------
// poly_mult_result_collector_if
//
// Groups the input and output stream handshakes of the polynomial-multiplier
// result collector into one bundle.
//
// Input stream (product coefficients c_k from the PE chain):
//   in_valid  - in_data/in_last are valid this cycle
//   in_ready  - collector accepts a word this cycle
//   in_data   - product coefficient c_k, 2N bits
//   in_last   - final coefficient of a product
// Output stream (folded coefficients r_j to the NTT/storage logic):
//   out_valid - out_data holds a result coefficient
//   out_ready - downstream accepts out_data this cycle
//   out_data  - folded coefficient r_j, 2N bits
//   out_index - coefficient index j
//   out_last  - high with r_(L-1)
//
// master: the producer/consumer side (PE chain + downstream logic).
// slave : the collector itself.
// ---------------------------------------------------------------------------
interface poly_mult_result_collector_if #(
    parameter int N = 4,
    parameter int L = 4
);
    localparam int W  = 2 * N;
    localparam int IW = (L > 1) ? $clog2(L) : 1;

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [IW-1:0] out_index;
    logic          out_last;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_index,
        input  out_last,
        output out_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready,
        output out_valid,
        output out_data,
        output out_index,
        output out_last,
        input  out_ready
    );
endinterface

// File: rtl/poly_mult_result_collector.sv
// ---------------------------------------------------------------------------
// poly_mult_result_collector
//
// Sink end of the systolic polynomial-multiplier array. Takes the full
// linear-convolution product c_0..c_(2L-2), folds the upper half back onto
// the lower half (negacyclic: x^L = -1, cyclic: x^L = +1), buffers the L
// folded coefficients and streams them out over valid/ready.
//
// Ports:
//   clk      - system clock, all state changes on the rising edge
//   rst      - synchronous active-high reset, discards any frame in flight
//   bus      - slave side of the input/output stream bundle
//   busy     - high from the first accepted word until the last result
//              handshake
//   err_len  - one-cycle pulse when a product had the wrong length
//
// Parameters:
//   N          - operand width; product/result words are 2N bits
//   L          - polynomial length (L >= 2)
//   NEGACYCLIC - 1 subtracts wrapped terms, 0 adds them
// ---------------------------------------------------------------------------
module poly_mult_result_collector #(
    parameter int N          = 4,
    parameter int L          = 4,
    parameter bit NEGACYCLIC = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    poly_mult_result_collector_if.slave   bus,
    output logic                          busy,
    output logic                          err_len
);
    localparam int W  = 2 * N;
    localparam int IW = (L > 1) ? $clog2(L) : 1;
    // k must reach 2L-2; $clog2(2L) always covers that value.
    localparam int KW = $clog2(2 * L);

    localparam logic [KW-1:0] K_L    = KW'(L);
    localparam logic [KW-1:0] K_LAST = KW'(2 * L - 2);
    localparam logic [IW-1:0] J_LAST = IW'(L - 1);

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [0:0]    state;
    logic [KW-1:0] k;
    logic [IW-1:0] j;
    logic [W-1:0]  coef_buf [L];

    logic          in_fire;
    logic          out_fire;
    logic          last_term;
    logic [IW-1:0] wr_idx;
    logic [W-1:0]  wrapped;

    // Handshake qualification and the buffer slot the current word lands in.
    // Words c_0..c_(L-1) map straight onto slots 0..L-1; later words fold
    // back onto slot k-L.
    always_comb begin
        in_fire   = bus.in_valid && (state == ST_ACCUM);
        out_fire  = bus.out_ready && (state == ST_DRAIN);
        last_term = (k == K_LAST);
        wr_idx    = '0;
        if (k < K_L) begin
            wr_idx = IW'(k);
        end else begin
            wr_idx = IW'(k - K_L);
        end
        if (NEGACYCLIC) begin
            wrapped = coef_buf[wr_idx] - bus.in_data;
        end else begin
            wrapped = coef_buf[wr_idx] + bus.in_data;
        end
    end

    assign bus.in_ready  = (state == ST_ACCUM);
    assign bus.out_valid = (state == ST_DRAIN);
    // Outputs are forced to zero outside DRAIN so the idle bus is quiet.
    assign bus.out_data  = (state == ST_DRAIN) ? coef_buf[j] : '0;
    assign bus.out_index = (state == ST_DRAIN) ? j : '0;
    assign bus.out_last  = (state == ST_DRAIN) && (j == J_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_ACCUM;
            k       <= '0;
            j       <= '0;
            busy    <= 1'b0;
            err_len <= 1'b0;
            for (int i = 0; i < L; i++) begin
                coef_buf[i] <= '0;
            end
        end else begin
            err_len <= 1'b0;

            if (in_fire) begin
                if (k < K_L) begin
                    coef_buf[wr_idx] <= bus.in_data;
                end else begin
                    coef_buf[wr_idx] <= wrapped;
                end
                busy <= 1'b1;
                k    <= k + 1'b1;

                // An early last leaves slots above k unwritten by this
                // frame; clear them so stale coefficients never leak out.
                // For k >= L-1 there are no such slots.
                if (bus.in_last) begin
                    for (int i = 0; i < L; i++) begin
                        if (KW'(i) > k) begin
                            coef_buf[i] <= '0;
                        end
                    end
                end

                if (last_term || bus.in_last) begin
                    state   <= ST_DRAIN;
                    k       <= '0;
                    j       <= '0;
                    err_len <= !(last_term && bus.in_last);
                end
            end

            if (out_fire) begin
                j <= j + 1'b1;
                if (j == J_LAST) begin
                    state <= ST_ACCUM;
                    j     <= '0;
                    busy  <= 1'b0;
                end
            end
        end
    end
endmodule
